// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - state encoding and counter width shared by the ALU operator sequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_WAIT_A   = 2'd0,
    S_WAIT_B   = 2'd1,
    S_WAIT_OP  = 2'd2,
    S_SHOW_RES = 2'd3
  } seq_state_t;

  localparam int OPS_CNT_W = 8;

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - raw button to one-clock press: 2-FF sync, optional debounce, rising-edge detect
// Debounce stage present only when ALU_SEQ_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0] r_sync;
  logic [1:0] r_vld;
  logic       r_armed;
  logic       r_edge;
  logic       w_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b00;
      r_vld  <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_vld  <= {r_vld[0], 1'b1};
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_db;

  // Level flips only after the synchronized input disagrees for DEBOUNCE_CYCLES straight clocks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync[1] == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt <= '0;
      r_db  <= r_sync[1];
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_level = r_db;
`else
  assign w_level = r_sync[1];
`endif

  // Arm only once a real low has propagated through the synchronizer, so a held button never fires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_armed <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_armed <= r_armed | (r_vld[1] & ~r_sync[1]);
      r_edge  <= w_level;
    end
  end

  assign o_press = w_level & ~r_edge & r_armed;

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - ENTER/UNDO driven A -> B -> opcode -> result sequencer feeding ALU_REG
// Optional button debounce selected by ALU_SEQ_DEBOUNCE_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned OP_W            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enter_btn,
  input  logic                 undo_btn,
  input  logic [DATA_W-1:0]    sw,
  output logic [DATA_W-1:0]    data_in,
  output logic                 load_A,
  output logic                 load_B,
  output logic                 load_Op,
  output logic                 updateRes,
  output logic [1:0]           stage,
  output logic [OPS_CNT_W-1:0] ops_done
);

  seq_state_t           r_state, w_state_nxt;
  logic [DATA_W-1:0]    r_data, w_data_nxt;
  logic                 r_ld_a, r_ld_b, r_ld_op;
  logic                 w_ld_a, w_ld_b, w_ld_op;
  logic [OPS_CNT_W-1:0] r_ops, w_ops_nxt;
  logic                 w_press_e, w_press_u;
  logic                 w_go_e, w_go_u;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_btn   (enter_btn),
    .o_press (w_press_e)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_undo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_btn   (undo_btn),
    .o_press (w_press_u)
  );

  // Simultaneous presses are treated as ambiguous and dropped.
  assign w_go_e = w_press_e & ~w_press_u;
  assign w_go_u = w_press_u & ~w_press_e;

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_ld_op     = 1'b0;
    w_ops_nxt   = r_ops;
    case (r_state)
      S_WAIT_A: begin
        if (w_go_e) begin
          w_data_nxt  = sw;
          w_ld_a      = 1'b1;
          w_state_nxt = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (w_go_e) begin
          w_data_nxt  = sw;
          w_ld_b      = 1'b1;
          w_state_nxt = S_WAIT_OP;
        end else if (w_go_u) begin
          w_state_nxt = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (w_go_e) begin
          w_data_nxt           = '0;
          w_data_nxt[OP_W-1:0] = sw[OP_W-1:0];
          w_ld_op              = 1'b1;
          w_ops_nxt            = r_ops + OPS_CNT_W'(1);
          w_state_nxt          = S_SHOW_RES;
        end else if (w_go_u) begin
          w_state_nxt = S_WAIT_B;
        end
      end
      S_SHOW_RES: begin
        if (w_go_e) begin
          w_state_nxt = S_WAIT_A;
        end else if (w_go_u) begin
          w_state_nxt = S_WAIT_OP;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT_A;
      r_data  <= '0;
      r_ld_a  <= 1'b0;
      r_ld_b  <= 1'b0;
      r_ld_op <= 1'b0;
      r_ops   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_ld_a  <= w_ld_a;
      r_ld_b  <= w_ld_b;
      r_ld_op <= w_ld_op;
      r_ops   <= w_ops_nxt;
    end
  end

  assign data_in   = r_data;
  assign load_A    = r_ld_a;
  assign load_B    = r_ld_b;
  assign load_Op   = r_ld_op;
  assign updateRes = (r_state == S_SHOW_RES);
  assign stage     = r_state;
  assign ops_done  = r_ops;

endmodule
